uart_tx_fifo: RTL

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo_if.sv | 14 +
 rtl/uart_tx_fifo.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_if.sv
// Write-side handshake between a word producer and the UART transmitter FIFO.
//   tx_valid : producer requests a write of tx_data
//   tx_data  : DATA_W-bit word to transmit
//   tx_ready : FIFO has room; a word is accepted on a clock edge with valid & ready
interface uart_tx_fifo_if #(
  parameter int unsigned DATA_W = 8
) ();
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ready;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a first-word-fall-through FIFO.
// Frames are start, DATA_W data bits LSB first, optional parity, one or two
// stop bits. Baud/parity/stop settings are latched per frame when the head
// word is popped, so mid-frame configuration changes only affect later frames.
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   tx_if (slave)      : tx_valid / tx_data / tx_ready write handshake
//   bsp_set            : baud select 0=9600 1=19200 2=38400 3=57600 4=115200 else 9600
//   parity_mode        : 0/3 none, 1 odd, 2 even
//   stop2              : two stop bits when high
//   uart_txd           : serial line, idle high
//   tx_busy            : high while a frame is on the line
//   fifo_level         : number of stored words, 0..FIFO_DEPTH
//   overflow           : sticky, set by a write attempt while full
module uart_tx_fifo #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst_n,
  uart_tx_fifo_if.slave               tx_if,
  input  logic [2:0]                  bsp_set,
  input  logic [1:0]                  parity_mode,
  input  logic                        stop2,
  output logic                        uart_txd,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow
);

  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W     = PTR_W + 1;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned IDX_W     = $clog2(DATA_W);
  localparam int unsigned BPS_9600   = CLK_FREQ / 9600   - 1;
  localparam int unsigned BPS_19200  = CLK_FREQ / 19200  - 1;
  localparam int unsigned BPS_38400  = CLK_FREQ / 38400  - 1;
  localparam int unsigned BPS_57600  = CLK_FREQ / 57600  - 1;
  localparam int unsigned BPS_115200 = CLK_FREQ / 115200 - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  count;
  logic [LVL_W-1:0]  count_n;
  logic              ready_q;
  logic              push;
  logic              pop_c;
  logic [DATA_W-1:0] head_c;

  // Frame engine
  state_t            state;
  state_t            state_n;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_n;
  logic [CNT_W-1:0]  bps_c;
  logic              bit_end;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_n;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_n;
  logic [2:0]        bsp_q;
  logic [2:0]        bsp_n;
  logic              par_en_q;
  logic              par_en_n;
  logic              par_q;
  logic              par_n;
  logic              stop2_q;
  logic              stop2_n;
  logic              txd_c;
  logic              txd_q;
  logic              busy_q;

  // Write side: tx_ready is a registered "not full" flag, so a write and a
  // pop in the same cycle while full still drops the write.
  assign push           = tx_if.tx_valid & ready_q;
  assign tx_if.tx_ready = ready_q;
  assign head_c         = mem[rd_ptr];
  assign count_n        = count + LVL_W'(push) - LVL_W'(pop_c);

  assign uart_txd   = txd_q;
  assign tx_busy    = busy_q;
  assign fifo_level = count;

  // FIFO storage array (no reset needed; validity tracked by count)
  always_ff @(posedge sys_clk) begin
    if (push) begin
      mem[wr_ptr] <= tx_if.tx_data;
    end
  end

  // FIFO pointers, level, full flag and sticky overflow
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ready_q  <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count   <= count_n;
      ready_q <= (count_n != LVL_W'(FIFO_DEPTH));
      if (tx_if.tx_valid && !ready_q) begin
        overflow <= 1'b1;
      end
    end
  end

  // Bit period terminal count for the latched baud selection
  always_comb begin
    bps_c = CNT_W'(BPS_9600);
    case (bsp_q)
      3'd1:    bps_c = CNT_W'(BPS_19200);
      3'd2:    bps_c = CNT_W'(BPS_38400);
      3'd3:    bps_c = CNT_W'(BPS_57600);
      3'd4:    bps_c = CNT_W'(BPS_115200);
      default: bps_c = CNT_W'(BPS_9600);
    endcase
  end

  assign bit_end = (cnt == bps_c);

  // FSM state register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state, frame datapath updates and line level.
  // Every state change happens on bit_end, so the cycle counter naturally
  // restarts at zero on each state entry.
  always_comb begin
    state_n  = state;
    cnt_n    = bit_end ? '0 : cnt + CNT_W'(1);
    idx_n    = idx;
    shreg_n  = shreg;
    bsp_n    = bsp_q;
    par_en_n = par_en_q;
    par_n    = par_q;
    stop2_n  = stop2_q;
    pop_c    = 1'b0;
    txd_c    = 1'b1;

    case (state)
      S_IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        if (count != '0) begin
          pop_c    = 1'b1;
          shreg_n  = head_c;
          bsp_n    = bsp_set;
          par_en_n = (parity_mode == 2'd1) || (parity_mode == 2'd2);
          par_n    = (^head_c) ^ (parity_mode == 2'd1);
          stop2_n  = stop2;
          state_n  = S_START;
        end
      end
      S_START: begin
        txd_c = 1'b0;
        if (bit_end) begin
          state_n = S_DATA;
        end
      end
      S_DATA: begin
        txd_c = shreg[0];
        if (bit_end) begin
          shreg_n = shreg >> 1;
          if (idx == IDX_W'(DATA_W - 1)) begin
            idx_n   = '0;
            state_n = par_en_q ? S_PARITY : S_STOP;
          end else begin
            idx_n = idx + IDX_W'(1);
          end
        end
      end
      S_PARITY: begin
        txd_c = par_q;
        if (bit_end) begin
          state_n = S_STOP;
        end
      end
      S_STOP: begin
        txd_c = 1'b1;
        if (bit_end) begin
          if (stop2_q && (idx == '0)) begin
            idx_n = IDX_W'(1);
          end else begin
            idx_n   = '0;
            state_n = S_IDLE;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Frame registers and registered line outputs (one cycle behind the FSM)
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt      <= '0;
      idx      <= '0;
      shreg    <= '0;
      bsp_q    <= '0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      stop2_q  <= 1'b0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      cnt      <= cnt_n;
      idx      <= idx_n;
      shreg    <= shreg_n;
      bsp_q    <= bsp_n;
      par_en_q <= par_en_n;
      par_q    <= par_n;
      stop2_q  <= stop2_n;
      txd_q    <= txd_c;
      busy_q   <= (state != S_IDLE);
    end
  end

endmodule
